// File: rtl/i2c_pkg.sv
// i2c_pkg: state encoding and bus constants shared by the I2C target blocks.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        DEV,
        DEV_ACK,
        REG,
        REG_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK
    } state_t;

    // Level on SDA during the ninth clock of a byte.
    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: brings SCL/SDA into the clk domain (two synchronizer flops plus
// one history flop each) and flags SCL edges and START/STOP conditions.
module i2c_line_sync
    import i2c_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    // [0],[1] = synchronizer, [2] = previous synchronized value
    logic [2:0] scl_q, scl_d;
    logic [2:0] sda_q, sda_d;

    assign scl_d = {scl_q[1:0], scl_i};
    assign sda_d = {sda_q[1:0], sda_i};

    // Shift the raw lines in; reset to the idle-bus level so reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_q <= 3'b111;
            sda_q <= 3'b111;
        end else begin
            scl_q <= scl_d;
            sda_q <= sda_d;
        end
    end

    assign sda_o      = sda_q[1];
    assign scl_rise_o =  scl_q[1] & ~scl_q[2];
    assign scl_fall_o = ~scl_q[1] &  scl_q[2];
    // SDA may only move while SCL is held high for START/STOP.
    assign start_o    = scl_q[1] & scl_q[2] &  sda_q[2] & ~sda_q[1];
    assign stop_o     = scl_q[1] & scl_q[2] & ~sda_q[2] &  sda_q[1];

endmodule

// File: rtl/i2c_target.sv
// i2c_target: I2C responder with a register pointer; writes come out as one-cycle
// strobes, reads are served from a combinational register-file port.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [7:0] DEVICE = 8'h72
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       busy
);

    logic sda_s, scl_rise, scl_fall, bus_start, bus_stop;

    i2c_line_sync u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .scl_i      (scl),
        .sda_i      (sda_in),
        .sda_o      (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (bus_start),
        .stop_o     (bus_stop)
    );

    state_t      state_q, state_d;
    logic [3:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  ptr_q, ptr_d;
    logic        sda_oe_q, sda_oe_d;
    logic        wr_valid_q, wr_valid_d;
    logic [7:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        busy_q, busy_d;
    logic        rw_q, rw_d;
    logic        ackhi_q, ackhi_d;   // ACK currently being driven in an *_ACK state
    logic [7:0]  byte_in;

    assign byte_in = {shift_q[6:0], sda_s};

    // Next-state: bus events first, then per-state bit handling on SCL edges.
    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        sda_oe_d   = sda_oe_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        busy_d     = busy_q;
        rw_d       = rw_q;
        ackhi_d    = ackhi_q;

        if (bus_stop) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            bitcnt_d = 4'd0;
            ackhi_d  = 1'b0;
        end else if (bus_start) begin
            // Repeated START keeps the pointer and drops any partial byte.
            state_d  = DEV;
            bitcnt_d = 4'd0;
            ackhi_d  = 1'b0;
        end else begin
            case (state_q)
                DEV, REG, WDATA: begin
                    if (scl_rise) begin
                        shift_d  = byte_in;
                        bitcnt_d = bitcnt_q + 4'd1;
                        if (bitcnt_q == 4'd7) begin
                            bitcnt_d = 4'd0;
                            ackhi_d  = 1'b0;
                            if (state_q == DEV) begin
                                if (byte_in[7:1] == DEVICE[7:1]) begin
                                    state_d = DEV_ACK;
                                    busy_d  = 1'b1;
                                    rw_d    = byte_in[0];
                                end else begin
                                    state_d = IDLE;
                                end
                            end else if (state_q == REG) begin
                                ptr_d   = byte_in;
                                state_d = REG_ACK;
                            end else begin
                                wr_valid_d = 1'b1;
                                wr_addr_d  = ptr_q;
                                wr_data_d  = byte_in;
                                ptr_d      = ptr_q + 8'd1;
                                state_d    = WDATA_ACK;
                            end
                        end
                    end
                end
                DEV_ACK, REG_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!ackhi_q) begin
                            sda_oe_d = ~ACK;
                            ackhi_d  = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            ackhi_d  = 1'b0;
                            bitcnt_d = 4'd0;
                            if (state_q == DEV_ACK && rw_q) begin
                                // First read bit must be on the wire before the next rise.
                                state_d  = RDATA;
                                sda_oe_d = ~rd_data[7];
                                shift_d  = {rd_data[6:0], 1'b0};
                                bitcnt_d = 4'd1;
                            end else if (state_q == DEV_ACK) begin
                                state_d = REG;
                            end else begin
                                state_d = WDATA;
                            end
                        end
                    end
                end
                RDATA: begin
                    if (scl_fall) begin
                        if (bitcnt_q == 4'd0) begin
                            sda_oe_d = ~rd_data[7];
                            shift_d  = {rd_data[6:0], 1'b0};
                            bitcnt_d = 4'd1;
                        end else if (bitcnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            bitcnt_d = 4'd0;
                            state_d  = RDATA_ACK;
                        end else begin
                            sda_oe_d = ~shift_q[7];
                            shift_d  = {shift_q[6:0], 1'b0};
                            bitcnt_d = bitcnt_q + 4'd1;
                        end
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise) begin
                        if (sda_s == NACK) begin
                            state_d  = IDLE;
                            sda_oe_d = 1'b0;
                        end else begin
                            // Pointer moves now so rd_data is settled by the reload edge.
                            ptr_d    = ptr_q + 8'd1;
                            bitcnt_d = 4'd0;
                            state_d  = RDATA;
                        end
                    end
                end
                default: ;
            endcase
        end

        if (state_d == IDLE) begin
            busy_d = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bitcnt_q   <= 4'd0;
            shift_q    <= 8'd0;
            ptr_q      <= 8'd0;
            sda_oe_q   <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= 8'd0;
            wr_data_q  <= 8'd0;
            busy_q     <= 1'b0;
            rw_q       <= 1'b0;
            ackhi_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            sda_oe_q   <= sda_oe_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            rw_q       <= rw_d;
            ackhi_q    <= ackhi_d;
        end
    end

    assign sda_oe   = sda_oe_q;
    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign rd_addr  = ptr_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: I2C initiator model at clk/16 driving the target, with a
// transaction-level model of the register file and pointer.
module tb_i2c_target;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_in;
    logic       sda_oe, wr_valid, busy;
    logic [7:0] wr_addr, wr_data, rd_addr, rd_data;

    logic [7:0] user_mem  [0:255];
    logic [7:0] model_mem [0:255];
    logic       mem_init = 1'b1;

    logic [7:0] exp_a[$], exp_d[$];
    logic [7:0] got_a[$], got_d[$];
    logic [7:0] got_rd[$];
    logic [7:0] model_ptr = 8'd0;
    logic       silent = 1'b0;
    logic [7:0] wdat [0:7];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign sda_in  = sda_m & ~sda_oe;
    assign rd_data = user_mem[rd_addr];

    i2c_target #(.DEVICE(8'h72)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl      (scl),
        .sda_in   (sda_in),
        .sda_oe   (sda_oe),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .busy     (busy)
    );

    function automatic logic [7:0] seed_val(input int i);
        if (i == 8'h41) return 8'h10;
        if (i == 8'h42) return 8'hA5;
        return 8'((i * 37 + 11) & 255);
    endfunction

    // User register file: preloaded, then written by the DUT's strobes.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) user_mem[i] <= seed_val(i);
        end else if (wr_valid) begin
            user_mem[wr_addr] <= wr_data;
        end
    end

    // Per-cycle compare: every strobe against the model queue; SDA silence when unaddressed.
    always @(negedge clk) begin
        if (rst_n && !mem_init) begin
            if (wr_valid) begin
                n_checks++;
                got_a.push_back(wr_addr);
                got_d.push_back(wr_data);
                if (exp_a.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_strobe: got addr=0x%02h data=0x%02h, expected no strobe",
                             wr_addr, wr_data);
                end else begin
                    logic [7:0] ea, ed;
                    ea = exp_a.pop_front();
                    ed = exp_d.pop_front();
                    if (wr_addr !== ea || wr_data !== ed) begin
                        n_fail++;
                        $display("FAIL strobe: got (0x%02h,0x%02h), expected (0x%02h,0x%02h)",
                                 wr_addr, wr_data, ea, ed);
                    end
                end
            end
            if (silent) begin
                n_checks++;
                if (sda_oe !== 1'b0) begin
                    n_fail++;
                    $display("FAIL silent_sda_oe: got %b, expected 0", sda_oe);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One initiator-driven bit; SCL is low on entry and on exit.
    task automatic bit_out(input logic b);
        tick(4); sda_m = b; tick(4); scl = 1'b1; tick(8); scl = 1'b0;
    endtask

    // One bit driven by the target; sampled mid-high.
    task automatic bit_in(output logic b);
        tick(4); sda_m = 1'b1; tick(4); scl = 1'b1; tick(4); b = sda_in; tick(4); scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v, output logic ack);
        for (int i = 7; i >= 0; i--) bit_out(v[i]);
        bit_in(ack);
    endtask

    task automatic recv_byte(input logic ack, output logic [7:0] v);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            bit_in(b);
            v[i] = b;
        end
        bit_out(ack);
    endtask

    task automatic bus_start();
        if (scl == 1'b0) begin
            tick(4); sda_m = 1'b1; tick(4); scl = 1'b1;
        end
        tick(4); sda_m = 1'b0; tick(4); scl = 1'b0;
    endtask

    task automatic bus_stop();
        tick(4); sda_m = 1'b0; tick(4); scl = 1'b1; tick(4); sda_m = 1'b1; tick(8);
    endtask

    task automatic end_checks();
        tick(2);
        chk("busy_after_stop", busy, 0);
        chk("rd_addr_ptr", rd_addr, model_ptr);
        chk("strobes_pending", exp_a.size(), 0);
    endtask

    // Write transaction: addressed iff dev[7:1] matches 0x72's upper bits.
    task automatic write_txn(input logic [7:0] dev, input logic [7:0] regb, input int n);
        logic a;
        logic matched;
        matched = (dev[7:1] == 7'h39);
        silent  = !matched;
        bus_start();
        send_byte(dev, a);
        chk("dev_ack", a, matched ? 0 : 1);
        chk("busy_addressed", busy, matched);
        if (matched) model_ptr = regb;
        send_byte(regb, a);
        chk("reg_ack", a, matched ? 0 : 1);
        for (int i = 0; i < n; i++) begin
            if (matched) begin
                exp_a.push_back(model_ptr);
                exp_d.push_back(wdat[i]);
                model_mem[model_ptr] = wdat[i];
                model_ptr = model_ptr + 8'd1;
            end
            send_byte(wdat[i], a);
            chk("data_ack", a, matched ? 0 : 1);
        end
        bus_stop();
        silent = 1'b0;
        end_checks();
    endtask

    // Pointer write then repeated-START read of n bytes; last byte NACKed.
    task automatic read_txn(input logic [7:0] regb, input int n);
        logic a;
        logic [7:0] v;
        bus_start();
        send_byte(8'h72, a);
        chk("rd_dev_ack", a, 0);
        send_byte(regb, a);
        chk("rd_reg_ack", a, 0);
        model_ptr = regb;
        bus_start();
        send_byte(8'h73, a);
        chk("rd_dev73_ack", a, 0);
        for (int i = 0; i < n; i++) begin
            recv_byte((i == n - 1), v);
            got_rd.push_back(v);
            chk("rd_byte", v, model_mem[model_ptr]);
            if (i != n - 1) model_ptr = model_ptr + 8'd1;
        end
        bus_stop();
        end_checks();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic a;
        for (int i = 0; i < 256; i++) model_mem[i] = seed_val(i);
        tick(4);
        mem_init = 1'b0;
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rd_addr", rd_addr, 0);
        rst_n = 1'b1;
        tick(4);

        // Single write
        got_a.delete(); got_d.delete();
        wdat[0] = 8'h03;
        write_txn(8'h72, 8'h98, 1);
        chk("t1_count", got_a.size(), 1);
        chk("t1_addr", got_a[0], 8'h98);
        chk("t1_data", got_d[0], 8'h03);

        // Foreign address
        got_a.delete(); got_d.delete();
        write_txn(8'h70, 8'h98, 0);
        chk("t2_count", got_a.size(), 0);

        // Burst write
        wdat[0] = 8'h00; wdat[1] = 8'h70; wdat[2] = 8'h46;
        write_txn(8'h72, 8'h15, 3);
        chk("t3_count", got_a.size(), 3);
        chk("t3_s0", {got_a[0], got_d[0]}, 16'h1500);
        chk("t3_s1", {got_a[1], got_d[1]}, 16'h1670);
        chk("t3_s2", {got_a[2], got_d[2]}, 16'h1746);

        // Read with repeated START
        got_a.delete(); got_d.delete(); got_rd.delete();
        read_txn(8'h41, 2);
        chk("t4_byte0", got_rd[0], 8'h10);
        chk("t4_byte1", got_rd[1], 8'hA5);
        chk("t4_no_strobe", got_a.size(), 0);
        chk("t4_rd_addr", rd_addr, 8'h42);

        // STOP after 4 data bits
        bus_start();
        send_byte(8'h72, a);
        chk("t5_dev_ack", a, 0);
        send_byte(8'h50, a);
        chk("t5_reg_ack", a, 0);
        model_ptr = 8'h50;
        for (int i = 7; i >= 4; i--) bit_out(i[0]);
        bus_stop();
        end_checks();
        chk("t5_no_strobe", got_a.size(), 0);
        wdat[0] = 8'h55;
        write_txn(8'h72, 8'h20, 1);
        chk("t5_count", got_a.size(), 1);
        chk("t5_strobe", {got_a[0], got_d[0]}, 16'h2055);

        // Reset while the target drives ACK
        got_a.delete(); got_d.delete();
        bus_start();
        send_byte(8'h72, a);
        send_byte(8'h30, a);
        model_ptr = 8'h30;
        exp_a.push_back(8'h30); exp_d.push_back(8'h11);
        model_mem[8'h30] = 8'h11;
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] v;
            v = 8'h11;
            bit_out(v[i]);
        end
        tick(6);
        chk("t6_ack_driven", sda_oe, 1);
        rst_n = 1'b0;
        tick(1);
        chk("t6_sda_released", sda_oe, 0);
        chk("t6_ptr_reset", rd_addr, 0);
        model_ptr = 8'h00;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        scl = 1'b1; tick(8); scl = 1'b0;
        bus_stop();
        chk("t6_busy", busy, 0);
        got_a.delete(); got_d.delete();
        wdat[0] = 8'hAB; wdat[1] = 8'hCD;
        write_txn(8'h72, 8'h60, 2);
        chk("t6_s0", {got_a[0], got_d[0]}, 16'h60AB);
        chk("t6_s1", {got_a[1], got_d[1]}, 16'h61CD);

        // Randomized transactions
        for (int k = 0; k < 16; k++) begin
            logic [7:0] regb, dev;
            int n;
            regb = 8'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                n = $urandom_range(1, 4);
                for (int i = 0; i < n; i++) wdat[i] = 8'($urandom);
                dev = 8'h72;
                if ($urandom_range(0, 3) == 0) begin
                    dev = 8'($urandom_range(0, 127) << 1);
                    if (dev[7:1] == 7'h39) dev = 8'h74;
                end
                write_txn(dev, regb, n);
            end else begin
                n = $urandom_range(1, 3);
                read_txn(regb, n);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C responder (target) for the same bus protocol that the display path's ADV7513 configuration writer initiates.
- Decodes START/STOP, matches a 7-bit device address, and takes a register-pointer byte.
- Each received data byte is emitted as a one-cycle register-write strobe. Reads return bytes from a register-file port.
- Used as a simulation/bring-up model of the HDMI transmitter's control port, and as the control slave for in-fabric peripherals.

Parameters:
- DEVICE, 8'h72, 8-bit write address of this target; bit 0 is ignored on compare.

Ports:
- clk, input, 1, system clock; all logic on posedge.
- rst_n, input, 1, synchronous active-low reset.
- scl, input, 1, bus clock; external open-drain, asynchronous to clk.
- sda_in, input, 1, bus data as read from the pad.
- sda_oe, output, 1, 1 = pull SDA low; 0 = release.
- wr_valid, output, 1, one-cycle strobe: wr_addr/wr_data are valid.
- wr_addr, output, 8, register address for the write.
- wr_data, output, 8, data byte for the write.
- rd_addr, output, 8, current register pointer for reads.
- rd_data, input, 8, register contents at rd_addr; combinational from the user.
- busy, output, 1, high from an addressed START until STOP or NACK.

Behaviour:
- Input conditioning:
  - scl and sda_in each pass through 2 synchronizer flops plus 1 history flop.
  - Edges are detected on the synchronized copies, so edge-to-action latency is 3 clk.
  - clk must be at least 8x the SCL rate.
- Bus events (synchronized signals):
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Both are recognised in every state and take priority over bit handling in the same cycle.
- Bit timing:
  - SDA is sampled on the SCL rising edge.
  - sda_oe changes only on the SCL falling edge, except for reset and STOP.
- States:
  - IDLE -> DEV on START.
  - DEV: shift 8 bits MSB first. After the 8th bit:
    - if bits[7:1] == DEVICE[7:1], go to DEV_ACK;
    - otherwise go to IDLE with no ACK.
  - DEV_ACK: on the next falling edge assert sda_oe; on the following falling edge release it. Then go to:
    - REG if R/W = 0;
    - RDATA if R/W = 1, loading the shift register from rd_data.
  - REG: 8 bits into the pointer -> REG_ACK (ACK as above) -> WDATA.
  - WDATA: 8 bits, then:
    - pulse wr_valid for exactly 1 clk, with wr_addr = pointer and wr_data = byte;
    - go to WDATA_ACK;
    - pointer increments by 1 (mod 256) after the strobe.
    - WDATA_ACK (ACK as above) -> WDATA.
  - RDATA: drive sda_oe = ~bit on each falling edge, MSB first. After 8 bits release SDA -> RDATA_ACK.
  - RDATA_ACK: sample the initiator's bit on the rising edge.
    - 0 (ACK): pointer+1, reload from rd_data, go to RDATA.
    - 1 (NACK): go to IDLE and release SDA.
- Repeated START in any state:
  - go to DEV; pointer is retained; any partial byte is discarded without a strobe.
- STOP in any state:
  - go to IDLE; sda_oe = 0 in the same cycle; partial byte discarded.
- busy:
  - set on entry to DEV_ACK with a matching address;
  - cleared in IDLE.
- rd_addr always equals the pointer.
- Reset values:
  - sda_oe = 0, wr_valid = 0, wr_addr = 0, wr_data = 0, busy = 0;
  - pointer = 0, state IDLE, bit counter 0;
  - synchronizer flops = 1 (idle bus).
- Reset asserted mid-transfer:
  - SDA released on the cycle after the rst_n sample;
  - the bus is ignored until the next START.

Decomposition:
- Shared package i2c_pkg holds:
  - state enum (IDLE, DEV, DEV_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK);
  - constants ACK = 1'b0, NACK = 1'b1.
- One natural sub-module, i2c_line_sync: the 2-flop synchronizer plus edge/START/STOP detector, shared with any future I2C block.

Test Plan:
- Drive with an I2C initiator model at clk/16: START, 0x72, 0x98, 0x03, STOP.
  - Expect ACK on all three 9th clocks.
  - Expect exactly one wr_valid with wr_addr = 0x98, wr_data = 0x03.
  - Expect busy low after STOP.
- START, 0x70, 0x98, STOP.
  - Expect sda_oe never asserted, no wr_valid, busy stays 0.
- Burst: START, 0x72, 0x15, 0x00, 0x70, 0x46, STOP.
  - Expect three strobes, in order: (0x15, 0x00), (0x16, 0x70), (0x17, 0x46).
- Read: START, 0x72, 0x41, repeated START, 0x73; bench returns rd_data = 0x10 when rd_addr = 0x41 and 0xA5 when rd_addr = 0x42.
  - Initiator ACKs the first byte and NACKs the second, then STOP.
  - Expect SDA bytes 0x10 and 0xA5.
  - Expect no wr_valid and final state IDLE.
- STOP after 4 bits of a data byte.
  - Expect no strobe.
  - A following write of 0x72, 0x20, 0x55 strobes (0x20, 0x55).
- Assert rst_n = 0 while the target is driving ACK.
  - Expect sda_oe = 0 within 1 clk and pointer = 0.
  - A subsequent full write transaction completes normally.
